// File: rtl/writeback_buffer.sv
// Writeback buffer between a data cache and memory.
// Dirty victims queue in a small FIFO and drain to memory one block at a time.
// Cache fills that hit a queued victim are forwarded without touching memory,
// and the forwarded entry still drains afterwards.
module writeback_buffer #(
    parameter int WORD_SIZE  = 32,
    parameter int BLOCK_SIZE = 1024,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  evict_valid,
    output logic                  evict_ready,
    input  logic [WORD_SIZE-1:0]  evict_addr,
    input  logic [BLOCK_SIZE-1:0] evict_data,
    input  logic                  fill_req,
    input  logic [WORD_SIZE-1:0]  fill_addr,
    output logic                  fill_valid,
    output logic [BLOCK_SIZE-1:0] fill_data,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [WORD_SIZE-1:0]  mem_addr,
    output logic [BLOCK_SIZE-1:0] mem_wdata,
    input  logic [BLOCK_SIZE-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam int OFS_W = 7;
    localparam int TAG_W = WORD_SIZE - OFS_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, FWD} state_t;

    state_t                  state_q;
    logic [TAG_W-1:0]        addr_mem_q [DEPTH];
    logic [BLOCK_SIZE-1:0]   data_mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    evict_ready_q;
    logic                    fill_valid_q;
    logic [BLOCK_SIZE-1:0]   fill_data_q;
    logic                    mem_we_q, mem_re_q;
    logic [WORD_SIZE-1:0]    mem_addr_q;

    logic                    push_s, pop_s;
    logic [TAG_W-1:0]        fill_tag_s, evict_tag_s;
    logic                    hit_s;
    logic [BLOCK_SIZE-1:0]   hit_data_s;
    logic [PTR_W-1:0]        idx_s;
    logic                    unused_ofs_s;

    assign fill_tag_s   = fill_addr[WORD_SIZE-1:OFS_W];
    assign evict_tag_s  = evict_addr[WORD_SIZE-1:OFS_W];
    assign unused_ofs_s = ^{fill_addr[OFS_W-1:0], evict_addr[OFS_W-1:0]};
    assign push_s       = evict_valid && evict_ready_q;
    assign pop_s        = (state_q == WRITE) && mem_ack;

    assign evict_ready = evict_ready_q;
    assign fill_valid  = fill_valid_q;
    assign fill_data   = fill_data_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = data_mem_q[rd_ptr_q];
    assign flush_done  = rst_n && flush && (count_q == {CNT_W{1'b0}}) && (state_q == IDLE);

    // Next FIFO pointers and occupancy; push and pop in one cycle leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and ready registers; ready is held low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            evict_ready_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            evict_ready_q <= (count_d != CNT_W'(DEPTH));
        end
    end

    // Victim storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_q[wr_ptr_q] <= evict_tag_s;
            data_mem_q[wr_ptr_q] <= evict_data;
        end
    end

    // Youngest-match search: walk oldest to youngest so later hits win, same-cycle push wins last.
    always_comb begin
        hit_s      = 1'b0;
        hit_data_s = {BLOCK_SIZE{1'b0}};
        idx_s      = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_mem_q[idx_s] == fill_tag_s)) begin
                hit_s      = 1'b1;
                hit_data_s = data_mem_q[idx_s];
            end else begin
                hit_s      = hit_s;
                hit_data_s = hit_data_s;
            end
        end
        if (push_s && (evict_tag_s == fill_tag_s)) begin
            hit_s      = 1'b1;
            hit_data_s = evict_data;
        end else begin
            hit_s      = hit_s;
            hit_data_s = hit_data_s;
        end
    end

    // Control FSM with registered memory/fill outputs; a single request is ever outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= {WORD_SIZE{1'b0}};
            fill_valid_q <= 1'b0;
            fill_data_q  <= {BLOCK_SIZE{1'b0}};
        end else begin
            fill_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fill_req && !fill_valid_q) begin
                        if (hit_s) begin
                            fill_data_q <= hit_data_s;
                            state_q     <= FWD;
                        end else if (count_q == CNT_W'(DEPTH)) begin
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= {addr_mem_q[rd_ptr_q], {OFS_W{1'b0}}};
                            state_q    <= WRITE;
                        end else begin
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= {fill_tag_s, {OFS_W{1'b0}}};
                            state_q    <= READ;
                        end
                    end else if (count_q != {CNT_W{1'b0}}) begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= {addr_mem_q[rd_ptr_q], {OFS_W{1'b0}}};
                        state_q    <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_we_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        mem_re_q     <= 1'b0;
                        fill_data_q  <= mem_rdata;
                        fill_valid_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                FWD: begin
                    fill_valid_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    mem_we_q <= 1'b0;
                    mem_re_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: drain, forwarding, duplicates, full buffer,
// flush completion and reset during a read.
module tb_writeback_buffer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          evict_valid;
    logic          evict_ready;
    logic [31:0]   evict_addr;
    logic [1023:0] evict_data;
    logic          fill_req;
    logic [31:0]   fill_addr;
    logic          fill_valid;
    logic [1023:0] fill_data;
    logic          flush;
    logic          flush_done;
    logic          mem_we, mem_re;
    logic [31:0]   mem_addr;
    logic [1023:0] mem_wdata;
    logic [1023:0] mem_rdata;
    logic          mem_ack;

    int n_cmp = 0;
    int n_err = 0;
    int re_cyc = 0;
    int re_before;

    writeback_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .evict_valid(evict_valid), .evict_ready(evict_ready),
        .evict_addr(evict_addr), .evict_data(evict_data),
        .fill_req(fill_req), .fill_addr(fill_addr),
        .fill_valid(fill_valid), .fill_data(fill_data),
        .flush(flush), .flush_done(flush_done),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Count cycles with a memory read request pending.
    always @(posedge clk) begin
        if (mem_re) re_cyc <= re_cyc + 1;
    end

    function automatic logic [1023:0] blk(input logic [31:0] k);
        return {32{k}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [1023:0] d);
        evict_valid = 1'b1;
        evict_addr  = a;
        evict_data  = d;
        step();
        evict_valid = 1'b0;
    endtask

    // Wait for a memory write, check it, hold it two cycles, then acknowledge.
    task automatic mem_write(input string tag, input logic [31:0] a, input logic [1023:0] d);
        for (int i = 0; i < 20 && !mem_we; i++) step();
        chk({tag, "_we"}, mem_we, 1'b1);
        chk({tag, "_re_low"}, mem_re, 1'b0);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_wdata"}, mem_wdata, d);
        step();
        step();
        chk({tag, "_we_held"}, mem_we, 1'b1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk({tag, "_we_drop"}, mem_we, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; evict_valid = 1'b0; evict_addr = 32'h0; evict_data = '0;
        fill_req = 1'b0; fill_addr = 32'h0; flush = 1'b1; mem_rdata = '0; mem_ack = 1'b0;
        step();
        step();
        chk("rst_ready", evict_ready, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_re", mem_re, 1'b0);
        chk("rst_fill_valid", fill_valid, 1'b0);
        chk("rst_flush_done", flush_done, 1'b0);
        flush = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", evict_ready, 1'b1);

        // Simple drain of one victim.
        push(32'h0000_0400, blk(32'hD0D0_0000));
        mem_write("drain", 32'h0000_0400, blk(32'hD0D0_0000));
        flush = 1'b1;
        #1;
        chk("drain_empty", flush_done, 1'b1);
        flush = 1'b0;

        // Forward from a queued entry, offset bits ignored.
        push(32'h0000_0400, blk(32'hD0D0_0000));
        fill_req = 1'b1; fill_addr = 32'h0000_047C;
        re_before = re_cyc;
        step();
        chk("fwd_early", fill_valid, 1'b0);
        step();
        chk("fwd_valid", fill_valid, 1'b1);
        chk("fwd_data", fill_data, blk(32'hD0D0_0000));
        chk("fwd_no_re_now", mem_re, 1'b0);
        fill_req = 1'b0;
        mem_write("fwd_drain", 32'h0000_0400, blk(32'hD0D0_0000));
        chk("fwd_no_re", re_cyc, re_before);

        // Duplicate address; fill alongside the second push picks the newest data.
        evict_valid = 1'b1; evict_addr = 32'h0000_0400; evict_data = blk(32'hD0D0_0000);
        step();
        evict_data = blk(32'hD1D1_1111);
        fill_req = 1'b1; fill_addr = 32'h0000_0400;
        step();
        evict_valid = 1'b0;
        chk("dup_early", fill_valid, 1'b0);
        step();
        chk("dup_valid", fill_valid, 1'b1);
        chk("dup_data", fill_data, blk(32'hD1D1_1111));
        fill_req = 1'b0;
        mem_write("dup_w0", 32'h0000_0400, blk(32'hD0D0_0000));
        mem_write("dup_w1", 32'h0000_0400, blk(32'hD1D1_1111));

        // Full buffer: fill miss waits for the head write, then reads memory.
        push(32'h0000_1000, blk(32'hAAAA_0001));
        push(32'h0000_3000, blk(32'hBBBB_0002));
        push(32'h0000_2000, blk(32'hCCCC_0003));
        push(32'h0000_2000, blk(32'hDDDD_0004));
        chk("full_ready", evict_ready, 1'b0);
        chk("full_we", mem_we, 1'b1);
        chk("full_head_addr", mem_addr, 32'h0000_1000);
        chk("full_head_data", mem_wdata, blk(32'hAAAA_0001));
        fill_req = 1'b1; fill_addr = 32'h0000_8010;
        step();
        chk("full_wait_re", mem_re, 1'b0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        chk("full_re", mem_re, 1'b1);
        chk("full_re_we", mem_we, 1'b0);
        chk("full_re_addr", mem_addr, 32'h0000_8000);
        chk("full_ready_again", evict_ready, 1'b1);
        mem_rdata = blk(32'h5EAD_0005);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("full_fill_valid", fill_valid, 1'b1);
        chk("full_fill_data", fill_data, blk(32'h5EAD_0005));
        fill_req = 1'b0;
        step();
        chk("full_pulse", fill_valid, 1'b0);
        chk("full_w1_addr", mem_addr, 32'h0000_3000);
        chk("full_w1_data", mem_wdata, blk(32'hBBBB_0002));
        // Fill during a write is evaluated after the pop: youngest stored duplicate wins.
        fill_req = 1'b1; fill_addr = 32'h0000_2040;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        chk("yng_early", fill_valid, 1'b0);
        step();
        chk("yng_valid", fill_valid, 1'b1);
        chk("yng_data", fill_data, blk(32'hDDDD_0004));
        fill_req = 1'b0;
        mem_write("yng_wc", 32'h0000_2000, blk(32'hCCCC_0003));
        mem_write("yng_wd", 32'h0000_2000, blk(32'hDDDD_0004));

        // Flush drain with a push arriving mid-drain.
        push(32'h0000_4000, blk(32'h0000_00A1));
        push(32'h0000_4080, blk(32'h0000_00A2));
        push(32'h0000_4100, blk(32'h0000_00A3));
        flush = 1'b1;
        #1;
        chk("fl_busy", flush_done, 1'b0);
        chk("fl_x_addr", mem_addr, 32'h0000_4000);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("fl_after_x", flush_done, 1'b0);
        mem_write("fl_y", 32'h0000_4080, blk(32'h0000_00A2));
        step();
        chk("fl_z_addr", mem_addr, 32'h0000_4100);
        push(32'h0000_4180, blk(32'h0000_00A4));
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("fl_delayed", flush_done, 1'b0);
        mem_write("fl_w", 32'h0000_4180, blk(32'h0000_00A4));
        chk("fl_done", flush_done, 1'b1);
        flush = 1'b0;
        #1;
        chk("fl_done_drop", flush_done, 1'b0);

        // Reset while a read is pending; late ack must be ignored.
        fill_req = 1'b1; fill_addr = 32'h0000_9000;
        step();
        chk("rr_re", mem_re, 1'b1);
        chk("rr_addr", mem_addr, 32'h0000_9000);
        step();
        rst_n = 1'b0;
        fill_req = 1'b0;
        #1;
        chk("rr_re_drop", mem_re, 1'b0);
        chk("rr_fv", fill_valid, 1'b0);
        chk("rr_ready", evict_ready, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        mem_rdata = blk(32'hEEEE_EEEE);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("rr_late_fv", fill_valid, 1'b0);
        chk("rr_late_re", mem_re, 1'b0);
        chk("rr_late_we", mem_we, 1'b0);
        step();
        chk("rr_late_fv2", fill_valid, 1'b0);
        chk("rr_ready_back", evict_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
